// File: rtl/warp_scheduler.sv
// warp_scheduler: per-SM warp issue scheduler.
// Each warp slot runs a small IDLE/READY/ISSUED lifecycle FSM. One READY warp
// per cycle is chosen by round-robin rotation starting after the last accepted
// warp. The choice goes to the issue stage over a valid/ready handshake. A
// presented-but-stalled choice is locked until it is accepted.
module warp_scheduler #(
  parameter int NUM_WARPS_PER_SM = 4,
  parameter int WARP_ID_W        = $clog2(NUM_WARPS_PER_SM)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_WARPS_PER_SM-1:0] warpLaunch,
  input  logic [NUM_WARPS_PER_SM-1:0] warpResume,
  input  logic [NUM_WARPS_PER_SM-1:0] warpFinish,
  input  logic                        issueReady,
  output logic                        issueValid,
  output logic [NUM_WARPS_PER_SM-1:0] issueWarpOH,
  output logic [WARP_ID_W-1:0]        issueWarpId,
  output logic [WARP_ID_W:0]          activeCount,
  output logic                        allIdle
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    ISSUED = 2'd2
  } warp_state_t;

  warp_state_t state_q [NUM_WARPS_PER_SM];
  warp_state_t state_d [NUM_WARPS_PER_SM];

  logic [WARP_ID_W-1:0] last_id;
  logic                 lock_valid;
  logic [WARP_ID_W-1:0] lock_id;

  logic                 sel_found;
  logic [WARP_ID_W-1:0] sel_id;
  logic [WARP_ID_W-1:0] cand_id;
  logic                 handshake;
  logic [WARP_ID_W:0]   count_d;

  // State register for the per-warp lifecycle FSMs.
  always_ff @(posedge clk) begin
    // NOTE: the state array is a handful of flops, so it is reset explicitly;
    // every slot must come out of reset IDLE, not just the issue pointer.
    for (int i = 0; i < NUM_WARPS_PER_SM; i++) begin
      if (reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        state_q[i] <= IDLE;
      end else begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Round-robin pick of the first READY warp after last_id, wrapping at the top.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip the assignment would infer a latch.
    sel_found = 1'b0;
    sel_id    = '0;
    cand_id   = '0;
    for (int k = 1; k <= NUM_WARPS_PER_SM; k++) begin
      cand_id = last_id + WARP_ID_W'(k);
      if (!sel_found && (state_q[cand_id] == READY)) begin
        sel_found = 1'b1;
        sel_id    = cand_id;
      end
    end
  end

  // Issue outputs: a locked choice overrides the rotation search.
  always_comb begin
    issueValid  = 1'b0;
    issueWarpId = '0;
    issueWarpOH = '0;
    if (lock_valid) begin
      issueValid  = 1'b1;
      issueWarpId = lock_id;
    end else if (sel_found) begin
      issueValid  = 1'b1;
      issueWarpId = sel_id;
    end
    if (issueValid) begin
      issueWarpOH[issueWarpId] = 1'b1;
    end
  end

  assign handshake = issueValid & issueReady;

  // Next-state logic for every warp slot; finish takes priority over resume.
  always_comb begin
    for (int i = 0; i < NUM_WARPS_PER_SM; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: begin
          if (warpLaunch[i]) state_d[i] = READY;
        end
        READY: begin
          if (handshake && (issueWarpId == WARP_ID_W'(i))) state_d[i] = ISSUED;
        end
        ISSUED: begin
          if (warpFinish[i])      state_d[i] = IDLE;
          else if (warpResume[i]) state_d[i] = READY;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Population count of non-IDLE slots after this cycle's transitions.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_WARPS_PER_SM; i++) begin
      if (state_d[i] != IDLE) count_d = count_d + {{WARP_ID_W{1'b0}}, 1'b1};
    end
  end

  // Rotation pointer, stall lock and registered active count.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_id     <= '1;
      lock_valid  <= 1'b0;
      lock_id     <= '0;
      activeCount <= '0;
    end else begin
      activeCount <= count_d;
      if (handshake) begin
        last_id    <= issueWarpId;
        lock_valid <= 1'b0;
      end else if (issueValid) begin
        lock_valid <= 1'b1;
        lock_id    <= issueWarpId;
      end
    end
  end

  assign allIdle = (activeCount == '0);

endmodule
